// File: rtl/kyber_pkg.sv
// Shared Kyber constants, eta encodings, FSM states and stream sizing helpers
// for the streaming CBD sampler.
package kyber_pkg;

    localparam int Q  = 3329;
    localparam int N  = 256;
    localparam int CW = 12;

    localparam logic [1:0] ETA2 = 2'd2;
    localparam logic [1:0] ETA3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Input words consumed by one polynomial.
    function automatic int words_f(input logic [1:0] eta, input int iw, input int n);
        return (n * 2 * int'(eta)) / iw;
    endfunction

    // Output beats produced by one polynomial.
    function automatic int beats_f(input int n, input int nl);
        return n / nl;
    endfunction

endpackage

// File: rtl/cbd_lane.sv
// One combinational CBD lane: turns 2*eta stream bits into a canonical mod-q
// coefficient. For eta=2 only i_bits[3:0] are meaningful.
module cbd_lane #(
    parameter int CW = 12,
    parameter int Q  = 3329
) (
    input  logic [5:0]    i_bits,
    input  logic [1:0]    i_eta,
    output logic [CW-1:0] o_coeff
);
    import kyber_pkg::*;

    logic       w_e3;
    logic [1:0] w_a;
    logic [1:0] w_b;

    assign w_e3 = (i_eta == ETA3);

    // a takes the first eta bits, b the following eta bits
    assign w_a = {1'b0, i_bits[0]} + {1'b0, i_bits[1]} + {1'b0, i_bits[2] & w_e3};
    assign w_b = {1'b0, w_e3 ? i_bits[3] : i_bits[2]}
               + {1'b0, w_e3 ? i_bits[4] : i_bits[3]}
               + {1'b0, i_bits[5] & w_e3};

    always_comb begin
        o_coeff = '0;
        if (w_a >= w_b) begin
            o_coeff = CW'(w_a - w_b);
        end else begin
            o_coeff = CW'(Q) - CW'(w_b - w_a);
        end
    end

endmodule

// File: rtl/cbd_stream.sv
// Streaming CBD_eta sampler: PRF byte words in, NL mod-q coefficients per beat
// out under valid/ready; the polynomial itself is never stored.
module cbd_stream #(
    parameter int IW = 64,
    parameter int NL = 8,
    parameter int CW = 12,
    parameter int Q  = 3329,
    parameter int N  = 256
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [1:0]         i_eta,
    input  logic [IW-1:0]      i_ibytes,
    input  logic               i_ibytes_valid,
    output logic               o_ibytes_ready,
    output logic [NL*CW-1:0]   o_coeffs,
    output logic               o_coeffs_valid,
    input  logic               i_coeffs_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    import kyber_pkg::*;

    localparam int BW     = 2 * IW;
    localparam int CNTW   = $clog2(BW + 1);
    localparam int WORDS2 = words_f(ETA2, IW, N);
    localparam int WORDS3 = words_f(ETA3, IW, N);
    localparam int WCW    = $clog2(WORDS3 + 1);
    localparam int BEATS  = beats_f(N, NL);
    localparam int BCW    = $clog2(BEATS + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_eta;
    logic [BW-1:0]       r_buf;
    logic [CNTW-1:0]     r_cnt;
    logic [WCW-1:0]      r_words;
    logic [BCW-1:0]      r_beats_formed;
    logic [BCW-1:0]      r_beats_acc;
    logic [NL*CW-1:0]    r_coeffs;
    logic                r_valid;
    logic                r_err;

    logic                w_eta_ok;
    logic                w_start_ok;
    logic [WCW-1:0]      w_words_tgt;
    logic [CNTW-1:0]     w_need;
    logic                w_accept;
    logic                w_drain;
    logic                w_form;
    logic                w_last;
    logic [IW-1:0]       w_word_lsb;
    logic [BW-1:0]       w_base;
    logic [CNTW-1:0]     w_cnt_base;
    logic [BW-1:0]       w_buf_next;
    logic [CNTW-1:0]     w_cnt_next;
    logic [5:0]          w_lane_bits [NL];
    logic [NL*CW-1:0]    w_lanes;

    assign w_eta_ok    = (i_eta == ETA2) || (i_eta == ETA3);
    assign w_start_ok  = (r_state == IDLE) && i_start && w_eta_ok;
    assign w_words_tgt = (r_eta == ETA3) ? WCW'(WORDS3) : WCW'(WORDS2);
    assign w_need      = (r_eta == ETA3) ? CNTW'(NL * 6) : CNTW'(NL * 4);

    assign o_ibytes_ready = (r_state == RUN) && (r_words < w_words_tgt) && (r_cnt <= CNTW'(IW));
    assign w_accept       = i_ibytes_valid && o_ibytes_ready;
    assign w_drain        = r_valid && i_coeffs_ready;
    assign w_form         = (r_state == RUN) && (r_cnt >= w_need)
                          && (r_beats_formed < BCW'(BEATS)) && (!r_valid || w_drain);
    assign w_last         = w_drain && (r_beats_acc == BCW'(BEATS - 1));

    // Byte 0 sits in the top byte of the word but is first in the bit stream.
    genvar gi;
    generate
        for (gi = 0; gi < IW / 8; gi++) begin : g_reorder
            assign w_word_lsb[8*gi +: 8] = i_ibytes[IW-8-8*gi +: 8];
        end
    endgenerate

    assign w_base     = w_form ? (r_buf >> w_need) : r_buf;
    assign w_cnt_base = w_form ? (r_cnt - w_need) : r_cnt;
    assign w_buf_next = w_accept ? (w_base | ({{IW{1'b0}}, w_word_lsb} << w_cnt_base)) : w_base;
    assign w_cnt_next = w_cnt_base + (w_accept ? CNTW'(IW) : CNTW'(0));

    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            assign w_lane_bits[gi] = (r_eta == ETA3) ? r_buf[6*gi +: 6] : {2'b00, r_buf[4*gi +: 4]};
            cbd_lane #(.CW(CW), .Q(Q)) u_lane (
                .i_bits  (w_lane_bits[gi]),
                .i_eta   (r_eta),
                .o_coeff (w_lanes[CW*gi +: CW])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state        <= IDLE;
            r_eta          <= ETA2;
            r_buf          <= '0;
            r_cnt          <= '0;
            r_words        <= '0;
            r_beats_formed <= '0;
            r_beats_acc    <= '0;
            r_coeffs       <= '0;
            r_valid        <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= (r_state == IDLE) && i_start && !w_eta_ok;
            if (w_start_ok) begin
                r_eta          <= i_eta;
                r_buf          <= '0;
                r_cnt          <= '0;
                r_words        <= '0;
                r_beats_formed <= '0;
                r_beats_acc    <= '0;
                r_valid        <= 1'b0;
            end else if (r_state == RUN) begin
                r_buf <= w_buf_next;
                r_cnt <= w_cnt_next;
                if (w_accept) r_words <= r_words + 1'b1;
                if (w_form) begin
                    r_coeffs       <= w_lanes;
                    r_valid        <= 1'b1;
                    r_beats_formed <= r_beats_formed + 1'b1;
                end else if (w_drain) begin
                    r_valid <= 1'b0;
                end
                if (w_drain) r_beats_acc <= r_beats_acc + 1'b1;
            end
        end
    end

    assign o_coeffs       = r_coeffs;
    assign o_coeffs_valid = r_valid;
    assign o_busy         = (r_state == RUN);
    assign o_done         = (r_state == DONE);
    assign o_err          = r_err;

endmodule

// File: doc/cbd_stream.md
Name: cbd_stream

Overview:
- Parametrised streaming successor of the CBD sampler for Kyber.
- Converts the PRF byte stream into one 256-coefficient polynomial sampled from CBD_eta, with eta = 2 or 3 selected per polynomial.
- Coefficients leave as canonical mod-q values (0..Q-1), NL lanes per beat, under valid/ready backpressure.
- The polynomial is not stored internally. Sits between the SHAKE/PRF output and the NTT input buffer.

Parameters:
- IW, 64: input word width in bits; must be a multiple of 8 and ≥ NL*6.
- NL, 8: coefficient lanes per output beat; must divide N.
- CW, 12: output coefficient width in bits.
- Q, 3329: modulus.
- N, 256: coefficients per polynomial.

Ports:
- i_clk, input, 1: clock.
- i_rstn, input, 1: asynchronous active-low reset.
- i_start, input, 1: one-cycle pulse; begins a polynomial; latches i_eta.
- i_eta, input, 2: 2 or 3; sampled only at i_start.
- i_ibytes, input, IW: input bytes; byte 0 in [IW-1:IW-8].
- i_ibytes_valid, input, 1: input word valid.
- o_ibytes_ready, output, 1: input word accepted when valid && ready.
- o_coeffs, output, NL*CW: lane k = coefficient (beat*NL+k), at [CW*k +: CW].
- o_coeffs_valid, output, 1: output beat valid.
- i_coeffs_ready, input, 1: downstream accepts the beat.
- o_busy, output, 1: high from the start edge until o_done.
- o_done, output, 1: one-cycle pulse after the last beat is accepted.
- o_err, output, 1: one-cycle pulse when i_start arrives with eta not in {2,3}.

Behaviour:
- Reset (asynchronous, any time, including mid-polynomial):
  - All outputs are 0; state IDLE.
  - Bit buffer, counters and output register are cleared.
  - No partial beat survives reset.
- Bit order:
  - Each accepted word is appended to an LSB-first bit buffer: byte 0 first, and bit 0 of each byte first (Kyber order).
- Coefficient computation, for coefficient j:
  - a = sum of bits 2*eta*j + t, for t < eta.
  - b = sum of bits 2*eta*j + eta + t, for t < eta.
  - d = a - b, in [-eta, eta].
  - Output d if d ≥ 0, else Q + d, zero-extended to CW bits.
- Bits per beat: NEED = NL*2*eta (32 or 48 at defaults).
- Words per polynomial: N*2*eta/IW (16 or 24 at defaults).
- Beats per polynomial: N/NL (32 at defaults).
- Buffer:
  - 2*IW bits, with occupancy count cnt.
  - o_ibytes_ready = busy && words_in < WORDS && cnt ≤ IW.
  - Simultaneous accept and beat-formation in one cycle: cnt_next = cnt + IW - NEED.
- Output register:
  - A beat is formed when cnt ≥ NEED, beats_out < BEATS, and the register is empty or being drained this cycle (o_coeffs_valid && i_coeffs_ready).
  - o_coeffs and o_coeffs_valid are registered.
  - While valid && !ready, o_coeffs is held stable.
- Latency: first beat valid on the 2nd rising edge after the first word handshake (buffer update, then register load).
- FSM:
  - IDLE: on i_start, eta valid → RUN (latch eta, clear counters, o_busy=1). Eta invalid → o_err=1 for one cycle, stay in IDLE.
  - RUN: move words and beats as above. When the beat with index BEATS-1 is accepted → DONE.
  - DONE: o_done=1 and o_busy=0 for one cycle → IDLE.
- Ignored events:
  - i_start in RUN or DONE is ignored; no o_err.
  - i_eta changes during RUN have no effect.
- Surplus input: after WORDS words, ready stays 0 even if valid is held.
- Word alignment: every eta/IW combination consumes exactly WORDS words, so the buffer is empty at DONE.

Decomposition:
- Shared package kyber_pkg holds:
  - Q, N, CW.
  - eta encodings ETA2 = 2'd2, ETA3 = 2'd3.
  - FSM state encoding IDLE / RUN / DONE.
  - WORDS and BEATS as functions of eta, IW and NL.
- One sub-module: cbd_lane, combinational.
  - Input: 6 bits plus eta (eta=2 uses the low 4 bits).
  - Output: CW-bit mod-q coefficient.
  - Instantiated NL times.
- Buffer, counters and FSM stay in cbd_stream.

Test Plan:
1. eta=2, 16 words of all-0x03 bytes, ready tied high → 32 beats, lanes alternate 2,0 (lane0=2, lane1=0, …); o_done one cycle after beat 31; exactly 16 words accepted.
2. eta=2, all-0x0C bytes → lanes alternate 3327,0; all-0xFF and all-0x00 inputs each give every coefficient 0.
3. eta=3, 24 words of repeating 0x07 bytes → coefficient pattern 3,3328,… repeating every 4 coefficients; 32 beats; i_ibytes_valid held high after word 24 → o_ibytes_ready stays 0.
4. Backpressure: i_coeffs_ready low for 5 cycles at beat 10 → o_coeffs stable and valid held; o_ibytes_ready drops once cnt > IW; final output matches the golden vector with no loss or duplication.
5. i_start with i_eta=1 → o_err pulse of 1 cycle, o_busy stays 0, o_ibytes_ready stays 0. Then a valid start with eta=2 runs normally.
6. i_rstn asserted at beat 10 of an eta=3 run → all outputs 0 immediately. A new eta=2 start then produces the golden polynomial; an i_start pulse during RUN has no effect.
